// File: rtl/qos_port_allocator_pkg.sv
// Shared types and width helpers for the MAZE output-port allocator.
// Holds the allocator state enum, index/age width functions and the requester index type.
package maze_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } alloc_state_e;

    // Width of a saturating wait counter that must reach age_max.
    function automatic int age_w(input int age_max);
        return (age_max < 1) ? 1 : $clog2(age_max + 1);
    endfunction

    // Requester index width; a single requester still needs one bit to exist.
    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int MAX_REQ = 5;

    typedef logic [idx_w(MAX_REQ)-1:0] req_idx_t;

endpackage

// File: rtl/qos_port_allocator_rr_pick.sv
// Rotating-priority one-hot picker: the first set bit of mask at or above ptr,
// wrapping at NUM_REQ-1 back to 0.
module rr_pick
    import maze_arb_pkg::*;
#(
    parameter int NUM_REQ = 5,
    localparam int IW     = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] mask,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] onehot,
    output logic               any
);

    int best_rank;
    int sel;
    int rank;

    // Rank each requester by its distance from ptr; the lowest ranked set bit wins.
    always_comb begin
        best_rank = NUM_REQ;
        sel       = 0;
        rank      = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rank = (i - int'(ptr) + NUM_REQ) % NUM_REQ;
            if (mask[i] && (rank < best_rank)) begin
                best_rank = rank;
                sel       = i;
            end
        end
    end

    assign any = |mask;

    always_comb begin
        onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            onehot[i] = any && (sel == i);
        end
    end

endmodule

// File: rtl/qos_port_allocator.sv
// Output-port allocator: QoS-aware round-robin with wormhole packet locking and
// per-requester aging so low-QoS traffic cannot starve behind high-QoS traffic.
module qos_port_allocator
    import maze_arb_pkg::*;
#(
    parameter int NUM_REQ = 5,
    parameter int AGE_MAX = 15,
    localparam int IW     = idx_w(NUM_REQ),
    localparam int AW     = age_w(AGE_MAX)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] qos,
    input  logic [NUM_REQ-1:0] tail,
    input  logic               out_ready,
    output logic [NUM_REQ-1:0] gnt,
    output logic               xfer,
    output logic               locked,
    output logic [IW-1:0]      owner_id
);

    alloc_state_e                 state;
    logic [IW-1:0]                ptr;
    logic [NUM_REQ-1:0][AW-1:0]   age;

    logic [NUM_REQ-1:0] aged_mask, high_mask;
    logic [NUM_REQ-1:0] aged_oh, high_oh, low_oh, owner_oh;
    logic               aged_any, high_any, low_any;
    logic [IW-1:0]      win, nxt;
    logic               tail_win;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_mask
        assign aged_mask[i] = req[i] && (age[i] == AW'(AGE_MAX));
        assign high_mask[i] = req[i] && qos[i];
        assign owner_oh[i]  = (int'(owner_id) == i);
    end

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick_aged (
        .mask(aged_mask), .ptr(ptr), .onehot(aged_oh), .any(aged_any)
    );
    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick_high (
        .mask(high_mask), .ptr(ptr), .onehot(high_oh), .any(high_any)
    );
    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick_low (
        .mask(req), .ptr(ptr), .onehot(low_oh), .any(low_any)
    );

    // Aged beats high beats plain; a locked packet bypasses arbitration entirely.
    always_comb begin
        gnt = '0;
        if (rst_n) begin
            if (state == LOCKED)
                gnt = owner_oh & req & {NUM_REQ{out_ready}};
            else if (out_ready) begin
                if (aged_any)      gnt = aged_oh;
                else if (high_any) gnt = high_oh;
                else if (low_any)  gnt = low_oh;
            end
        end
    end

    assign xfer     = (|(gnt & req)) & out_ready;
    assign tail_win = |(gnt & tail);

    always_comb begin
        win = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) win = IW'(i);
        end
    end

    assign nxt = (win == IW'(NUM_REQ - 1)) ? '0 : win + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            locked   <= 1'b0;
            owner_id <= '0;
            ptr      <= '0;
            age      <= '0;
        end else if (xfer) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (gnt[i])
                    age[i] <= '0;
                else if (req[i] && (age[i] != AW'(AGE_MAX)))
                    age[i] <= age[i] + 1'b1;
            end
            if (state == IDLE) begin
                ptr <= nxt;
                if (!tail_win) begin
                    state    <= LOCKED;
                    locked   <= 1'b1;
                    owner_id <= win;
                end
            end else if (tail_win) begin
                state    <= IDLE;
                locked   <= 1'b0;
                owner_id <= '0;
                ptr      <= nxt;
            end
        end
    end

endmodule

// File: tb/tb_qos_port_allocator.sv
// Bench for qos_port_allocator: two instances (AGE_MAX 15 and 3) driven identically,
// compared every cycle against a packet-level model, plus directed literal checks.
module tb_qos_port_allocator;

    localparam int N = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] req = '0, qos = '0, tail = '0;
    logic       out_ready = 1'b0;

    logic [4:0] gnt_d   [2];
    logic       xfer_d  [2];
    logic       lock_d  [2];
    logic [2:0] owner_d [2];

    int npass = 0;
    int ntotal = 0;

    // model state, one set per instance
    int amax    [2] = '{15, 3};
    bit m_lock  [2] = '{0, 0};
    int m_owner [2] = '{0, 0};
    int m_ptr   [2] = '{0, 0};
    int m_age   [2][N];

    always #5 clk = ~clk;

    qos_port_allocator #(.NUM_REQ(5), .AGE_MAX(15)) dut15 (
        .clk(clk), .rst_n(rst_n), .req(req), .qos(qos), .tail(tail),
        .out_ready(out_ready), .gnt(gnt_d[0]), .xfer(xfer_d[0]),
        .locked(lock_d[0]), .owner_id(owner_d[0])
    );

    qos_port_allocator #(.NUM_REQ(5), .AGE_MAX(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .req(req), .qos(qos), .tail(tail),
        .out_ready(out_ready), .gnt(gnt_d[1]), .xfer(xfer_d[1]),
        .locked(lock_d[1]), .owner_id(owner_d[1])
    );

    // Expected grant as a requester number (-1 = none) from the arbitration rules.
    function automatic int model_win(input int d);
        int w;
        w = -1;
        if (!rst_n) return -1;
        if (m_lock[d]) return (req[m_owner[d]] && out_ready) ? m_owner[d] : -1;
        if (!out_ready) return -1;
        for (int lvl = 0; lvl < 3 && w < 0; lvl++) begin
            for (int k = 0; k < N && w < 0; k++) begin
                int i;
                bit cand;
                i = (m_ptr[d] + k) % N;
                case (lvl)
                    0:       cand = req[i] && (m_age[d][i] == amax[d]);
                    1:       cand = req[i] && qos[i];
                    default: cand = req[i];
                endcase
                if (cand) w = i;
            end
        end
        return w;
    endfunction

    function automatic logic [4:0] onehot5(input int w);
        logic [4:0] v;
        v = '0;
        if (w >= 0) v[w] = 1'b1;
        return v;
    endfunction

    task automatic chk(input string name, input int d, input logic [31:0] got, input logic [31:0] exp);
        ntotal++;
        if (got === exp) npass++;
        else $display("FAIL %s (age_max=%0d) t=%0t: got %0h want %0h", name, amax[d], $time, got, exp);
    endtask

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            int w;
            w = model_win(d);
            if (!rst_n) begin
                m_lock[d] = 0; m_owner[d] = 0; m_ptr[d] = 0;
                for (int i = 0; i < N; i++) m_age[d][i] = 0;
            end else if (w >= 0) begin
                for (int i = 0; i < N; i++) begin
                    if (i == w) m_age[d][i] = 0;
                    else if (req[i] && m_age[d][i] < amax[d]) m_age[d][i]++;
                end
                if (!m_lock[d]) begin
                    m_ptr[d] = (w + 1) % N;
                    if (!tail[w]) begin m_lock[d] = 1; m_owner[d] = w; end
                end else if (tail[w]) begin
                    m_lock[d] = 0; m_owner[d] = 0; m_ptr[d] = (w + 1) % N;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            int w;
            w = model_win(d);
            chk("gnt",    d, 32'(gnt_d[d]),   32'(onehot5(w)));
            chk("xfer",   d, 32'(xfer_d[d]),  32'(w >= 0));
            chk("locked", d, 32'(lock_d[d]),  32'(m_lock[d]));
            chk("owner",  d, 32'(owner_d[d]), 32'(m_owner[d]));
        end
    end

    task automatic apply(input logic r, input logic [4:0] rq, input logic [4:0] q,
                         input logic [4:0] t, input logic o);
        @(posedge clk); #1;
        rst_n = r; req = rq; qos = q; tail = t; out_ready = o;
        @(negedge clk); #1;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) for (int i = 0; i < N; i++) m_age[d][i] = 0;

        // reset forces zero grant regardless of inputs
        apply(0, 5'b11111, 5'b00000, 5'b11111, 1);
        chk("rst_gnt", 0, 32'(gnt_d[0]), 32'h0);
        chk("rst_xfer", 0, 32'(xfer_d[0]), 32'h0);
        apply(0, 5'b11111, 5'b00000, 5'b11111, 1);
        chk("rst_locked", 0, 32'(lock_d[0]), 32'h0);
        chk("rst_owner", 0, 32'(owner_d[0]), 32'h0);

        // basic rotation between 0 and 1, ptr ends at 2
        apply(1, 5'b00011, 5'b00000, 5'b11111, 1); chk("rot0", 0, 32'(gnt_d[0]), 32'b00001);
        apply(1, 5'b00011, 5'b00000, 5'b11111, 1); chk("rot1", 0, 32'(gnt_d[0]), 32'b00010);
        apply(1, 5'b00011, 5'b00000, 5'b11111, 1); chk("rot2", 0, 32'(gnt_d[0]), 32'b00001);
        apply(1, 5'b00011, 5'b00000, 5'b11111, 1); chk("rot3", 0, 32'(gnt_d[0]), 32'b00010);
        apply(1, 5'b11111, 5'b00000, 5'b11111, 1); chk("rot_ptr2", 0, 32'(gnt_d[0]), 32'b00100);

        // QoS priority from ptr=0
        apply(0, 5'b00000, 5'b00000, 5'b00000, 0);
        for (int k = 0; k < 3; k++) begin
            apply(1, 5'b10001, 5'b10000, 5'b11111, 1);
            chk("qos_high", 0, 32'(gnt_d[0]), 32'b10000);
        end
        apply(1, 5'b00001, 5'b00000, 5'b11111, 1); chk("qos_low", 0, 32'(gnt_d[0]), 32'b00001);

        // 3-flit packet from requester 2 while requester 0 waits (ptr=1)
        apply(1, 5'b00101, 5'b00000, 5'b00001, 1); chk("pkt_f1", 0, 32'(gnt_d[0]), 32'b00100);
        apply(1, 5'b00101, 5'b00000, 5'b00001, 1); chk("pkt_f2", 0, 32'(gnt_d[0]), 32'b00100);
        chk("pkt_locked", 0, 32'(lock_d[0]), 32'h1);
        chk("pkt_owner", 0, 32'(owner_d[0]), 32'h2);
        apply(1, 5'b00101, 5'b00000, 5'b00101, 1); chk("pkt_f3", 0, 32'(gnt_d[0]), 32'b00100);
        apply(1, 5'b00101, 5'b00000, 5'b00001, 1);
        chk("pkt_unlock", 0, 32'(lock_d[0]), 32'h0);
        chk("pkt_next", 0, 32'(gnt_d[0]), 32'b00001);

        // backpressure mid-packet (requester 1 owns, 3 waits)
        apply(1, 5'b01010, 5'b00000, 5'b01000, 1); chk("bp_head", 0, 32'(gnt_d[0]), 32'b00010);
        for (int k = 0; k < 4; k++) begin
            apply(1, 5'b01010, 5'b00000, 5'b01000, 0);
            chk("bp_gnt", 0, 32'(gnt_d[0]), 32'h0);
            chk("bp_xfer", 0, 32'(xfer_d[0]), 32'h0);
            chk("bp_owner", 0, 32'(owner_d[0]), 32'h1);
        end
        apply(1, 5'b01010, 5'b00000, 5'b01010, 1); chk("bp_tail", 0, 32'(gnt_d[0]), 32'b00010);
        apply(1, 5'b01010, 5'b00000, 5'b01010, 1);
        chk("bp_unlock", 0, 32'(lock_d[0]), 32'h0);
        chk("bp_next", 0, 32'(gnt_d[0]), 32'b01000);

        // anti-starvation on the AGE_MAX=3 instance
        apply(0, 5'b00000, 5'b00000, 5'b00000, 0);
        for (int k = 0; k < 3; k++) begin
            apply(1, 5'b01010, 5'b01000, 5'b11111, 1);
            chk("age_high", 1, 32'(gnt_d[1]), 32'b01000);
        end
        apply(1, 5'b01010, 5'b01000, 5'b11111, 1); chk("age_aged", 1, 32'(gnt_d[1]), 32'b00010);
        apply(1, 5'b01010, 5'b01000, 5'b11111, 1); chk("age_cleared", 1, 32'(gnt_d[1]), 32'b01000);

        // reset during a packet owned by requester 4
        apply(0, 5'b00000, 5'b00000, 5'b00000, 0);
        apply(1, 5'b10000, 5'b00000, 5'b00000, 1); chk("mr_head", 0, 32'(gnt_d[0]), 32'b10000);
        apply(1, 5'b11111, 5'b00000, 5'b00000, 1);
        chk("mr_owner", 0, 32'(owner_d[0]), 32'h4);
        chk("mr_hold", 0, 32'(gnt_d[0]), 32'b10000);
        apply(0, 5'b11111, 5'b00000, 5'b00000, 1); chk("mr_rst_gnt", 0, 32'(gnt_d[0]), 32'h0);
        apply(1, 5'b11111, 5'b00000, 5'b11111, 1);
        chk("mr_locked", 0, 32'(lock_d[0]), 32'h0);
        chk("mr_owner0", 0, 32'(owner_d[0]), 32'h0);
        chk("mr_first", 0, 32'(gnt_d[0]), 32'b00001);

        // randomized traffic against the model
        for (int k = 0; k < 800; k++) begin
            apply(($urandom_range(0, 99) != 0), 5'($urandom), 5'($urandom),
                  5'($urandom) & 5'($urandom), ($urandom_range(0, 9) < 7));
        end

        @(posedge clk); #1;
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
